uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  UART receive controller. Generates the sample-enable tick for the external two-stage RX synchronizer.
//  Consumes that synchronizer's output and sequences the 16x-oversampled frame: start, data, [parity], stop.
//  Delivers each byte on a valid/ready handshake.
//  Sits between the pad-side synchronizer and the byte consumer (FIFO or command decoder).
// PARAMETERS
//  CLK_DIV    27  iClk cycles per oversample tick (>=2); 27 -> ~115200 baud x16 at 50 MHz
//  OVERSAMPLE 16  ticks per bit (fixed, power of 2)
//  DATA_BITS  8   data bits per frame, LSB first
// PORTS
//  iClk        in   1          system clock
//  iReset      in   1          synchronous, active-high reset
//  oSampleCE   out  1          1-cycle tick every CLK_DIV clocks; drives synchronizer CE
//  iRxSync     in   1          synchronized RX line (idle high)
//  oData       out  DATA_BITS  received byte, stable while oValid=1
//  oValid      out  1          byte available
//  iReady      in   1          consumer accepts byte when oValid&&iReady
//  oFrameErr   out  1          1-cycle pulse: stop bit sampled 0
//  oOverrun    out  1          1-cycle pulse: byte completed while previous still pending
//  oParityErr  out  1          1-cycle pulse, PARITY_EN only (tied 0 otherwise)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, divider/tick/bit counters 0; reset mid-frame aborts it, no oValid.
//  Divider: counts 0..CLK_DIV-1 free-running. oSampleCE=1 when count==CLK_DIV-1.
//   The divider runs in every state.
//  FSM advances and samples iRxSync only on oSampleCE cycles. tick_cnt is 4 bits and wraps 15->0.
//   IDLE:   iRxSync==0 -> START, tick_cnt=0.
//   START:  at tick_cnt==7 (mid start bit): iRxSync==1 -> IDLE (glitch reject).
//           Else tick_cnt=0, bit_idx=0 -> DATA.
//   DATA:   at tick_cnt==15: shift iRxSync into MSB of shift reg (shift right).
//           Then bit_idx++; after bit DATA_BITS-1 -> PARITY if enabled, else STOP.
//   PARITY: at tick_cnt==15: capture the parity bit -> STOP.
//   STOP:   at tick_cnt==15: iRxSync==1 -> byte complete; 0 -> oFrameErr pulse, byte discarded.
//           Either way -> IDLE (no wait for idle line).
//  Handshake:
//   - oValid rises the clock after completion and holds until oValid&&iReady; it clears the next clock.
//   - Completion while oValid=1 and no accept that cycle: oOverrun pulses; oData keeps the old byte.
//   - Completion in the same cycle as an accept: the new byte loads and oValid stays 1.
//  Error pulses are exactly one iClk wide. Frame or parity error never sets oValid.
// CONFIGURATION
//  Macro UART_RX_PARITY_EN:
//   - Defined: PARITY state is present and even parity is checked over data+parity bit.
//     A mismatch pulses oParityErr with the stop-bit result; the byte is discarded, no oValid.
//   - Undefined: 8N1 framing only, no PARITY state, oParityErr tied 0.
// STRUCTURE
//  Shared package uart_pkg holds:
//   - FSM state encodings (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP)
//   - OVERSAMPLE, MID_TICK=7, LAST_TICK=15
//   - a clog2 function for the divider width
//  Sub-module uart_baud_tick: CLK_DIV divider producing oSampleCE. Reused by the TX side.
// TESTING (CLK_DIV=4 -> 64 clocks/bit; synchronizer instantiated in bench)
//  1. Frame 0xA5 8N1, iReady=1 -> oValid for 1 clock, oData=0xA5, no error pulses.
//  2. Line low for 12 clocks then high -> FSM back to IDLE; no oValid, no errors.
//  3. Frame 0x3C with stop bit 0 -> oFrameErr 1-cycle pulse; oValid stays 0.
//  4. iReady=0, frames 0x11 then 0x22 -> oData=0x11 held with oValid=1; oOverrun pulses at 2nd stop.
//     Then iReady=1 -> oValid drops next clock.
//  5. iReset pulsed during data bit 4 -> all outputs 0; following frame 0x5A received intact.
//  6. UART_RX_PARITY_EN: 0x07 with parity bit 0 -> oParityErr pulse, no oValid.
//     0x07 with parity bit 1 -> oValid, oData=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants, width helper.
// Used by both the receive controller and the baud tick divider.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running CLK_DIV divider; tick is high for one clock
// each time the count reaches CLK_DIV-1.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int         W    = clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x oversampled start/data/[parity]/stop sequencing with
// valid/ready byte delivery. Define UART_RX_PARITY_EN for even-parity frames.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8
) (
  input  logic                 iClk,
  input  logic                 iReset,
  output logic                 oSampleCE,
  input  logic                 iRxSync,
  output logic [DATA_BITS-1:0] oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oFrameErr,
  output logic                 oOverrun,
  output logic                 oParityErr
);

  localparam int            IW       = clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [3:0]           tick_cnt, tick_n;
  logic [IW-1:0]        bit_idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 ce;
  logic                 done;
  logic                 stop_ok;
  logic                 par_ok;
  logic                 good;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (iClk),
    .reset (iReset),
    .tick  (ce)
  );

  assign oSampleCE = ce;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_n;
  // Even parity: data plus parity bit must hold an even number of ones
  assign par_ok = ~^{shift, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign good = done && stop_ok && par_ok;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_idx  <= idx_n;
      shift    <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    idx_n     = bit_idx;
    shift_n   = shift;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
`endif
    done      = 1'b0;
    stop_ok   = 1'b0;
    if (ce) begin
      unique case (state)
        ST_IDLE: begin
          if (!iRxSync) begin
            state_n = ST_START;
            tick_n  = '0;
          end
        end
        ST_START: begin
          if (tick_cnt == MID_TICK) begin
            if (iRxSync) begin
              state_n = ST_IDLE;
            end else begin
              tick_n  = '0;
              idx_n   = '0;
              state_n = ST_DATA;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        ST_DATA: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == LAST_TICK) begin
            shift_n = {iRxSync, shift[DATA_BITS-1:1]};
            idx_n   = bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == LAST_TICK) begin
            par_bit_n = iRxSync;
            state_n   = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == LAST_TICK) begin
            done    = 1'b1;
            stop_ok = iRxSync;
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // A pending unaccepted byte wins over a new one; the new byte is dropped
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oData     <= '0;
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oFrameErr <= done && !stop_ok;
      oOverrun  <= 1'b0;
      if (good) begin
        if (oValid && !iReady) begin
          oOverrun <= 1'b1;
        end else begin
          oData  <= shift;
          oValid <= 1'b1;
        end
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oParityErr <= 1'b0;
    end else begin
      oParityErr <= done && !par_ok;
    end
  end
`else
  assign oParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at CLK_DIV=4: frame table, corner sequences,
// and random frames against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BIT     = CLK_DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       rx_line = 1'b1;
  logic       s1      = 1'b1;
  logic       s2      = 1'b1;
  logic       ready   = 1'b1;
  logic       ce;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Two-stage synchronizer clocked by the DUT's sample enable
  always @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else if (ce) begin
      s1 <= rx_line;
      s2 <= s1;
    end
  end

  uart_rx_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (8)
  ) dut (
    .iClk       (clk),
    .iReset     (reset),
    .oSampleCE  (ce),
    .iRxSync    (s2),
    .oData      (data),
    .oValid     (valid),
    .iReady     (ready),
    .oFrameErr  (ferr),
    .oOverrun   (ovr),
    .oParityErr (perr)
  );

  // Output monitor: accepted bytes, pulse counts and high-cycle counts
  logic [7:0] acc_mem [512];
  int acc_n = 0, val_h = 0, val_p = 0;
  int ferr_p = 0, ferr_h = 0, ovr_p = 0, ovr_h = 0;
  int perr_p = 0, perr_h = 0;
  logic pv = 1'b0, pf = 1'b0, po = 1'b0, pp = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) begin
        acc_mem[acc_n[8:0]] = data;
        acc_n++;
      end
      if (valid) val_h++;
      if (valid && !pv) val_p++;
      if (ferr) ferr_h++;
      if (ferr && !pf) ferr_p++;
      if (ovr) ovr_h++;
      if (ovr && !po) ovr_p++;
      if (perr) perr_h++;
      if (perr && !pp) perr_p++;
      pv = valid;
      pf = ferr;
      po = ovr;
      pp = perr;
    end else begin
      pv = 1'b0;
      pf = 1'b0;
      po = 1'b0;
      pp = 1'b0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    step(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit(par);
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       par_ok;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] exp_q [$];

  initial begin
    int a0, f0, p0, o0, v0, vh0;
    int exp_f, exp_p;
    logic good;
    logic [7:0] d;
    logic st, pok;

    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h07, 1'b1, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 1'b0, 1'b0};
    vecs[7] = '{8'h5C, 1'b1, 1'b1};

    step(4);
    @(negedge clk);
    check("rst_ce", int'(ce), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_ferr", int'(ferr), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_perr", int'(perr), 0);
    reset = 1'b0;
    step(2 * BIT);

    // Frame table with ready held high
    foreach (vecs[k]) begin
      a0 = acc_n; f0 = ferr_p; p0 = perr_p;
      o0 = ovr_p; v0 = val_p; vh0 = val_h;
      good = vecs[k].stop && (!PAR || vecs[k].par_ok);
      send_frame(vecs[k].d, vecs[k].stop, ^vecs[k].d ^ !vecs[k].par_ok);
      check($sformatf("v%0d_acc", k), acc_n - a0, int'(good));
      check($sformatf("v%0d_vrise", k), val_p - v0, int'(good));
      check($sformatf("v%0d_vhigh", k), val_h - vh0, int'(good));
      check($sformatf("v%0d_ferr", k), ferr_p - f0, int'(!vecs[k].stop));
      check($sformatf("v%0d_perr", k), perr_p - p0,
            int'(PAR && !vecs[k].par_ok));
      check($sformatf("v%0d_ovr", k), ovr_p - o0, 0);
      if (good)
        check($sformatf("v%0d_data", k), int'(acc_mem[a0[8:0]]),
              int'(vecs[k].d));
    end

    // Short low glitch on an idle line
    a0 = acc_n; f0 = ferr_p; v0 = val_p; p0 = perr_p;
    rx_line = 1'b0;
    step(12);
    rx_line = 1'b1;
    step(3 * BIT);
    check("glitch_valid", val_p - v0, 0);
    check("glitch_ferr", ferr_p - f0, 0);
    check("glitch_perr", perr_p - p0, 0);
    a0 = acc_n;
    send_frame(8'hC3, 1'b1, ^8'hC3);
    check("glitch_after_acc", acc_n - a0, 1);
    check("glitch_after_data", int'(acc_mem[a0[8:0]]), 8'hC3);

    // Overrun: two frames while the consumer stalls
    ready = 1'b0;
    a0 = acc_n; o0 = ovr_p;
    send_frame(8'h11, 1'b1, ^8'h11);
    @(negedge clk);
    check("ovr_valid1", int'(valid), 1);
    check("ovr_data1", int'(data), 8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    @(negedge clk);
    check("ovr_pulse", ovr_p - o0, 1);
    check("ovr_data_held", int'(data), 8'h11);
    check("ovr_valid_held", int'(valid), 1);
    step(1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_at_accept", int'(valid), 1);
    @(negedge clk);
    check("ovr_valid_drop", int'(valid), 0);
    check("ovr_acc", acc_n - a0, 1);
    check("ovr_acc_data", int'(acc_mem[a0[8:0]]), 8'h11);

    // Reset mid-frame with a byte pending
    ready = 1'b0;
    send_frame(8'h99, 1'b1, ^8'h99);
    @(negedge clk);
    check("pre_rst_valid", int'(valid), 1);
    d = 8'h6B;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_line = d[4];
    step(BIT / 2);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_ce", int'(ce), 0);
    check("mid_rst_ferr", int'(ferr), 0);
    rx_line = 1'b1;
    step(1);
    reset = 1'b0;
    ready = 1'b1;
    step(2 * BIT);
    a0 = acc_n; f0 = ferr_p;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    check("post_rst_acc", acc_n - a0, 1);
    check("post_rst_data", int'(acc_mem[a0[8:0]]), 8'h5A);
    check("post_rst_ferr", ferr_p - f0, 0);

    // Random frames against the frame-level model
    a0 = acc_n; f0 = ferr_p; p0 = perr_p; o0 = ovr_p;
    exp_f = 0; exp_p = 0;
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      pok = ($urandom_range(0, 3) != 0);
      if (!st) exp_f++;
      if (PAR && !pok) exp_p++;
      if (st && (!PAR || pok)) exp_q.push_back(d);
      send_frame(d, st, ^d ^ !pok);
    end
    check("rnd_count", acc_n - a0, exp_q.size());
    check("rnd_ferr", ferr_p - f0, exp_f);
    check("rnd_perr", perr_p - p0, exp_p);
    check("rnd_ovr", ovr_p - o0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (a0 + i < acc_n)
        check($sformatf("rnd_byte%0d", i),
              int'(acc_mem[9'(a0 + i)]), int'(exp_q[i]));
    end

    check("ferr_width", ferr_h, ferr_p);
    check("ovr_width", ovr_h, ovr_p);
    check("perr_width", perr_h, perr_p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
